seg_code_rx: RTL

- Receive-side counterpart of the comparator-count-to-7-segment display driver.
- Samples a 7-segment pattern from an asynchronous source (remote display bus or test header) and synchronises it.
- Requires the pattern to be stable, then decodes it back to a count of 0..5 and regenerates the 5-bit comparator thermometer code.
- Delivers each new value over a valid/ready handshake to downstream logic (logger, checker FSM).

---
 rtl/seg_code_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_code_rx.sv
// ---------------------------------------------------------------------------
// seg_code_rx
//
// Receive side of the comparator-count to 7-segment display link. Samples an
// asynchronous active-low 7-segment pattern, waits until it has been stable
// for STABLE_CYCLES synchronised samples, decodes it back to a count of 0..5
// and the matching 5-bit comparator thermometer code, and presents each new
// value over a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   segs_in    in   [6:0] segment pattern, active-low, {g,f,e,d,c,b,a}
//   out_ready  in   downstream accepts the current value
//   out_valid  out  count/comps hold a new decoded value
//   count      out  [2:0] decoded count 0..5
//   comps      out  [4:0] thermometer code, comps[k]=1 iff k<count
//   err        out  one-cycle pulse on a stable illegal pattern
//   err_cnt    out  [7:0] saturating err pulse counter
//                   (present only when SEG_CODE_RX_ERR_CNT_EN is defined)
//
// Optional build macro: SEG_CODE_RX_ERR_CNT_EN
// ---------------------------------------------------------------------------
module seg_code_rx #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segs_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] count,
    output logic [4:0] comps,
    output logic       err
`ifdef SEG_CODE_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [6:0]       SEG_BLANK  = 7'h7F;
    localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_WAIT,
        ST_HOLD
    } state_e;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; only s2_q is ever decoded.
    // -----------------------------------------------------------------------
    logic [6:0] s1_q;
    logic [6:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= SEG_BLANK;
            s2_q <= SEG_BLANK;
        end else begin
            s1_q <= segs_in;
            s2_q <= s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stability counter. s2_q changes on this edge exactly when s1_q differs
    // from it, so that comparison restarts the count at 1.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (s1_q != s2_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != STABLE_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Pattern decode (active-low segments).
    // -----------------------------------------------------------------------
    logic [2:0] dec_digit;
    logic       dec_legal;
    logic       dec_blank;

    always_comb begin
        dec_digit = 3'd0;
        dec_legal = 1'b0;
        dec_blank = 1'b0;
        case (s2_q)
            7'h40: begin dec_digit = 3'd0; dec_legal = 1'b1; end
            7'h79: begin dec_digit = 3'd1; dec_legal = 1'b1; end
            7'h24: begin dec_digit = 3'd2; dec_legal = 1'b1; end
            7'h30: begin dec_digit = 3'd3; dec_legal = 1'b1; end
            7'h19: begin dec_digit = 3'd4; dec_legal = 1'b1; end
            7'h12: begin dec_digit = 3'd5; dec_legal = 1'b1; end
            7'h7F: dec_blank = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [4:0] therm(input logic [2:0] n);
        case (n)
            3'd0:    therm = 5'b00000;
            3'd1:    therm = 5'b00001;
            3'd2:    therm = 5'b00011;
            3'd3:    therm = 5'b00111;
            3'd4:    therm = 5'b01111;
            default: therm = 5'b11111;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Handshake FSM with registered outputs.
    // -----------------------------------------------------------------------
    logic [6:0] last_q;
    logic       stable;
    logic       new_pat;

    // A pattern is acted upon once: last_q records it whatever its class, so
    // a held illegal pattern pulses err only once and a held digit is not
    // re-emitted until some other stable pattern has been seen in between.
    assign stable  = (cnt_q == STABLE_VAL);
    assign new_pat = stable && (s2_q != last_q);

    state_e     state_q;
    logic       out_valid_q;
    logic [2:0] count_q;
    logic [4:0] comps_q;
    logic       err_q;
`ifdef SEG_CODE_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            comps_q     <= '0;
            err_q       <= 1'b0;
            last_q      <= SEG_BLANK;
`ifdef SEG_CODE_RX_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (new_pat) begin
                        last_q <= s2_q;
                        if (dec_legal) begin
                            count_q     <= dec_digit;
                            comps_q     <= therm(dec_digit);
                            out_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else if (!dec_blank) begin
                            err_q <= 1'b1;
`ifdef SEG_CODE_RX_ERR_CNT_EN
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                default: begin
                    state_q     <= ST_WAIT;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign comps     = comps_q;
    assign err       = err_q;
`ifdef SEG_CODE_RX_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule
